// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I run sequencer: FSM state encoding,
// halt-cause codes and the SYSTEM instruction encodings that stop a run.
package riscv_pkg;

  // Run sequencer states, in the order IDLE, LOAD, RUN, HALT.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } run_state_e;

  // Reason the last run stopped.
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_SYS     = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  localparam logic [1:0] CAUSE_TOHOST  = 2'b11;

  // Exact encodings of ECALL and EBREAK (all operand fields zero).
  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  // True when the CPU is executing an instruction that ends the program.
  function automatic logic is_sys_instr(input logic [31:0] instr);
    return (instr == INSTR_ECALL) || (instr == INSTR_EBREAK);
  endfunction

endpackage

// File: rtl/run_cycle_counter.sv
// Saturating RUN-cycle counter with synchronous clear and enable.
// tc flags that the current count equals MAX_CYCLES-1, i.e. the cycle
// being executed now is the last one allowed before a timeout halt.
module run_cycle_counter #(
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAT_VAL = '1;

  // Count enabled cycles, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en && (count != SAT_VAL)) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/riscv_run_ctrl.sv
// Run sequencer for the single-cycle RV32I CPU under test.
// Streams a program image into imem, holds the CPU in reset until start,
// releases it, counts RUN cycles and stops it on ECALL/EBREAK or timeout.
// Optional build macro: TOHOST_EN adds a store monitor on TOHOST_ADDR that
// halts with cause 11 and reports pass when the stored value is 1.
//
// Loader handshake: a word transfers on every rising clk edge where
// ld_valid and ld_ready are both high; ld_data/ld_last are only meaningful
// while ld_valid is high, and ld_ready does not depend on ld_valid.
module riscv_run_ctrl
  import riscv_pkg::*;
#(
  parameter int          IMEM_DEPTH  = 512,
  parameter int          MAX_CYCLES  = 100000,
  parameter int          CNT_W       = 32,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_start,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [31:0]                   ld_data,
  input  logic                          ld_last,
  output logic                          imem_we,
  output logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  output logic [31:0]                   imem_wdata,
  input  logic                          start,
  output logic                          cpu_reset,
  input  logic [31:0]                   PC,
  input  logic [31:0]                   Instr,
  input  logic                          MemWrite,
  input  logic [31:0]                   Mem_WrAddr,
  input  logic [31:0]                   Mem_WrData,
  output logic                          busy,
  output logic                          loaded,
  output logic                          load_ovf,
  output logic                          done,
  output logic [1:0]                    halt_cause,
  output logic [31:0]                   halt_pc,
  output logic                          pass,
  output logic [CNT_W-1:0]              cycle_count,
  output logic [1:0]                    state_dbg
);

  localparam int            AW        = $clog2(IMEM_DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(IMEM_DEPTH - 1);

  run_state_e    state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;
  logic          loaded_nxt, ovf_nxt, pass_nxt;
  logic [1:0]    cause_nxt;
  logic [31:0]   pc_nxt;
  logic          cnt_clr, cnt_en, cnt_tc;
  logic          ld_hs;
  logic          tohost_hit, tohost_pass;

  assign ld_hs = ld_valid && ld_ready;

`ifdef TOHOST_EN
  assign tohost_hit  = MemWrite && (Mem_WrAddr == TOHOST_ADDR);
  assign tohost_pass = (Mem_WrData == 32'd1);
`else
  // Store bus is not monitored in this build.
  logic unused_store_bus;
  assign unused_store_bus = ^{MemWrite, Mem_WrAddr, Mem_WrData, TOHOST_ADDR};
  assign tohost_hit  = 1'b0;
  assign tohost_pass = 1'b0;
`endif

  run_cycle_counter #(
    .CNT_W      (CNT_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_cycle_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cycle_count),
    .tc    (cnt_tc)
  );

  // State and result registers; reset aborts any load or run in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      loaded     <= 1'b0;
      load_ovf   <= 1'b0;
      halt_cause <= CAUSE_NONE;
      halt_pc    <= '0;
      pass       <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      loaded     <= loaded_nxt;
      load_ovf   <= ovf_nxt;
      halt_cause <= cause_nxt;
      halt_pc    <= pc_nxt;
      pass       <= pass_nxt;
    end
  end

  // Next-state logic: command decode in IDLE/HALT, image load, halt checks.
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    loaded_nxt = loaded;
    ovf_nxt    = load_ovf;
    cause_nxt  = halt_cause;
    pc_nxt     = halt_pc;
    pass_nxt   = pass;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    case (state)
      ST_IDLE, ST_HALT: begin
        // load_start takes priority; start needs a loaded image.
        if (load_start) begin
          state_nxt  = ST_LOAD;
          ptr_nxt    = '0;
          loaded_nxt = 1'b0;
          ovf_nxt    = 1'b0;
        end else if (start && loaded) begin
          state_nxt = ST_RUN;
          cnt_clr   = 1'b1;
          cause_nxt = CAUSE_NONE;
          pc_nxt    = '0;
          pass_nxt  = 1'b0;
        end
      end
      ST_LOAD: begin
        if (ld_hs) begin
          ptr_nxt = ptr + 1'b1;
          if (ld_last) begin
            state_nxt  = ST_IDLE;
            loaded_nxt = 1'b1;
          end else if (ptr == LAST_ADDR) begin
            // Image filled imem without a last marker: keep what fit.
            state_nxt  = ST_IDLE;
            loaded_nxt = 1'b1;
            ovf_nxt    = 1'b1;
          end
        end
      end
      ST_RUN: begin
        cnt_en = 1'b1;
        if (is_sys_instr(Instr)) begin
          state_nxt = ST_HALT;
          cause_nxt = CAUSE_SYS;
          pc_nxt    = PC;
        end else if (tohost_hit) begin
          state_nxt = ST_HALT;
          cause_nxt = CAUSE_TOHOST;
          pc_nxt    = PC;
          pass_nxt  = tohost_pass;
        end else if (cnt_tc) begin
          state_nxt = ST_HALT;
          cause_nxt = CAUSE_TIMEOUT;
          pc_nxt    = PC;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign ld_ready   = (state == ST_LOAD);
  assign imem_we    = ld_hs;
  assign imem_waddr = ptr;
  assign imem_wdata = ld_hs ? ld_data : 32'd0;
  assign cpu_reset  = (state != ST_RUN);
  assign busy       = (state == ST_LOAD) || (state == ST_RUN);
  assign done       = (state == ST_HALT);
  assign state_dbg  = state;

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Bench for riscv_run_ctrl: the bench plays both loader and CPU, drives
// randomized images and store traffic, and compares against a run model
// derived from the halt rules (first SYSTEM instruction, tohost store or
// the MAX_CYCLES-th cycle, whichever comes first).
module tb_riscv_run_ctrl;

  localparam int          DEPTH    = 4;
  localparam int          MAX_CYC  = 16;
  localparam int          AW       = $clog2(DEPTH);
  localparam int          W        = AW + 32;
  localparam logic [31:0] TOHOST   = 32'h0000_1000;
  localparam logic [31:0] I_ECALL  = 32'h0000_0073;
  localparam logic [31:0] I_EBREAK = 32'h0010_0073;
  localparam logic [31:0] I_ADDI1  = 32'h0010_0093;
  localparam logic [31:0] I_ADDI2  = 32'h0020_0113;
  localparam logic [31:0] I_NOP    = 32'h0000_0013;
  localparam logic [31:0] I_JAL0   = 32'h0000_006f;
  localparam logic [31:0] I_SW     = 32'h0011_2023;
`ifdef TOHOST_EN
  localparam bit TOHOST_ON = 1'b1;
`else
  localparam bit TOHOST_ON = 1'b0;
`endif

  logic          clk = 1'b0, reset;
  logic          load_start, ld_valid, ld_ready, ld_last;
  logic [31:0]   ld_data;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          start, cpu_reset;
  logic [31:0]   PC, Instr, Mem_WrAddr, Mem_WrData;
  logic          MemWrite;
  logic          busy, loaded, load_ovf, done, pass;
  logic [1:0]    halt_cause, state_dbg;
  logic [31:0]   halt_pc, cycle_count;

  riscv_run_ctrl #(
    .IMEM_DEPTH (DEPTH), .MAX_CYCLES (MAX_CYC), .CNT_W (32), .TOHOST_ADDR (TOHOST)
  ) dut (
    .clk (clk), .reset (reset), .load_start (load_start), .ld_valid (ld_valid),
    .ld_ready (ld_ready), .ld_data (ld_data), .ld_last (ld_last),
    .imem_we (imem_we), .imem_waddr (imem_waddr), .imem_wdata (imem_wdata),
    .start (start), .cpu_reset (cpu_reset), .PC (PC), .Instr (Instr),
    .MemWrite (MemWrite), .Mem_WrAddr (Mem_WrAddr), .Mem_WrData (Mem_WrData),
    .busy (busy), .loaded (loaded), .load_ovf (load_ovf), .done (done),
    .halt_cause (halt_cause), .halt_pc (halt_pc), .pass (pass),
    .cycle_count (cycle_count), .state_dbg (state_dbg)
  );

  // Clock generation.
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  cause;
    logic [31:0] pc;
    logic [31:0] count;
    logic        pass;
  } run_res_t;

  int          vectors = 0;
  int          miscompares = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  logic [31:0] load_buf[0:7];
  logic [31:0] shadow[0:DEPTH-1];
  bit          img_loaded;

  // Single comparison point.
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Record every imem write the DUT issues.
  always @(negedge clk) begin
    if (imem_we === 1'b1) obs_q.push_back({imem_waddr, imem_wdata});
  end

  function automatic bit is_store(input logic [31:0] ins);
    return ins[6:0] == 7'b0100011;
  endfunction

  // Reference run: step a sequential CPU over the shadow image.
  function automatic run_res_t model_run(input logic [31:0] st_addr, input logic [31:0] st_val);
    run_res_t    r;
    logic [31:0] pc;
    logic [31:0] ins;
    r  = '0;
    pc = 32'd0;
    for (int c = 0; c < MAX_CYC; c++) begin
      ins     = shadow[pc[AW+1:2]];
      r.count = 32'(c + 1);
      r.pc    = pc;
      if (ins == I_ECALL || ins == I_EBREAK) begin
        r.cause = 2'b01;
        return r;
      end
      if (TOHOST_ON && is_store(ins) && st_addr == TOHOST) begin
        r.cause = 2'b11;
        r.pass  = (st_val == 32'd1);
        return r;
      end
      if (c == MAX_CYC - 1) begin
        r.cause = 2'b10;
        return r;
      end
      if (ins != I_JAL0) pc = pc + 32'd4;
    end
    return r;
  endfunction

  task automatic pulse(input bit ls, input bit st);
    load_start = ls;
    start      = st;
    @(posedge clk); #1;
    load_start = 1'b0;
    start      = 1'b0;
  endtask

  // Present one CPU cycle on the fetch/store buses.
  task automatic drive_cpu(input logic [31:0] pc, input logic [31:0] st_addr,
                           input logic [31:0] st_val);
    logic [31:0] ins;
    ins        = shadow[pc[AW+1:2]];
    PC         = pc;
    Instr      = ins;
    MemWrite   = is_store(ins);
    Mem_WrAddr = st_addr;
    Mem_WrData = st_val;
  endtask

  // Stream load_buf[0..n-1] with random gaps and ignored commands.
  task automatic stream_words(input int n, input bit with_last, input string tag);
    int nw;
    logic [W-1:0] e, o;
    nw = (n < DEPTH) ? n : DEPTH;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        ld_valid = 1'b0;
        if (i < DEPTH) begin
          start      = 1'($urandom_range(0, 1));
          load_start = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        start      = 1'b0;
        load_start = 1'b0;
      end
      ld_valid = 1'b1;
      ld_data  = load_buf[i];
      ld_last  = with_last && (i == n - 1);
      if (i < DEPTH) exp_q.push_back({AW'(i), load_buf[i]});
      @(posedge clk); #1;
      if (!with_last && i == DEPTH - 1) check_eq({tag, "_ld_ready_after_ovf"}, ld_ready, 0);
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ld_data  = $urandom;
    check_eq({tag, "_write_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check_eq({tag, "_waddr"}, o[W-1:32], e[W-1:32]);
      check_eq({tag, "_wdata"}, o[31:0], e[31:0]);
    end
    exp_q.delete();
    obs_q.delete();
    check_eq({tag, "_loaded"}, loaded, 1);
    check_eq({tag, "_load_ovf"}, load_ovf, !with_last);
    check_eq({tag, "_state_idle"}, state_dbg, 0);
    check_eq({tag, "_busy"}, busy, 0);
    for (int i = 0; i < nw; i++) shadow[i] = load_buf[i];
    img_loaded = 1'b1;
  endtask

  task automatic load_image(input int n, input bit with_last, input string tag);
    pulse(1'b1, 1'b0);
    check_eq({tag, "_enter_load"}, state_dbg, 1);
    stream_words(n, with_last, tag);
  endtask

  // Start a run, play the CPU until it is put back in reset, then check results.
  task automatic run_and_check(input logic [31:0] st_addr, input logic [31:0] st_val,
                               input string tag);
    run_res_t    r;
    logic [31:0] pc;
    int          iter;
    r = model_run(st_addr, st_val);
    pulse(1'b0, 1'b1);
    check_eq({tag, "_run_cpu_reset"}, cpu_reset, 0);
    check_eq({tag, "_run_count0"}, cycle_count, 0);
    pc   = 32'd0;
    iter = 0;
    while (cpu_reset == 1'b0 && iter < MAX_CYC + 8) begin
      drive_cpu(pc, st_addr, st_val);
      start      = 1'($urandom_range(0, 1));
      load_start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      start      = 1'b0;
      load_start = 1'b0;
      if (Instr != I_JAL0) pc = pc + 32'd4;
      iter++;
    end
    MemWrite = 1'b0;
    check_eq({tag, "_run_length"}, iter, r.count);
    check_eq({tag, "_done"}, done, 1);
    check_eq({tag, "_halt_cause"}, halt_cause, r.cause);
    check_eq({tag, "_halt_pc"}, halt_pc, r.pc);
    check_eq({tag, "_cycle_count"}, cycle_count, r.count);
    check_eq({tag, "_pass"}, pass, r.pass);
    check_eq({tag, "_busy"}, busy, 0);
    repeat (2) begin
      Instr = I_ECALL;
      PC    = $urandom;
      @(posedge clk); #1;
    end
    check_eq({tag, "_hold_count"}, cycle_count, r.count);
    check_eq({tag, "_hold_pc"}, halt_pc, r.pc);
    check_eq({tag, "_hold_cpu_reset"}, cpu_reset, 1);
  endtask

  function automatic logic [31:0] rand_instr();
    case ($urandom_range(0, 9))
      0, 1:    return I_ADDI1;
      2, 3:    return I_NOP;
      4:       return I_ECALL;
      5:       return I_EBREAK;
      6:       return I_JAL0;
      7, 8:    return I_SW;
      default: return I_ADDI2;
    endcase
  endfunction

  initial begin
    logic [31:0] sa, sv;
    int          n;
    reset = 1'b1; load_start = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    ld_data = 32'hdead_beef; PC = '0; Instr = '0; MemWrite = 1'b0;
    Mem_WrAddr = '0; Mem_WrData = '0; img_loaded = 1'b0;
    for (int i = 0; i < DEPTH; i++) shadow[i] = I_NOP;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset values.
    check_eq("rst_state", state_dbg, 0);
    check_eq("rst_cpu_reset", cpu_reset, 1);
    check_eq("rst_ld_ready", ld_ready, 0);
    check_eq("rst_imem_we", imem_we, 0);
    check_eq("rst_imem_waddr", imem_waddr, 0);
    check_eq("rst_imem_wdata", imem_wdata, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_loaded", loaded, 0);
    check_eq("rst_load_ovf", load_ovf, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_halt_cause", halt_cause, 0);
    check_eq("rst_halt_pc", halt_pc, 0);
    check_eq("rst_pass", pass, 0);
    check_eq("rst_cycle_count", cycle_count, 0);

    // Start without an image is ignored.
    pulse(1'b0, 1'b1);
    check_eq("unloaded_start_state", state_dbg, 0);
    check_eq("unloaded_start_cpu_reset", cpu_reset, 1);

    // ADDI, ADDI, ECALL.
    load_buf[0] = I_ADDI1; load_buf[1] = I_ADDI2; load_buf[2] = I_ECALL;
    load_image(3, 1'b1, "ecall_prog");
    run_and_check(32'h0, 32'h0, "ecall_run");

    // Self-loop runs into the timeout.
    load_buf[0] = I_JAL0;
    load_image(1, 1'b1, "loop_prog");
    run_and_check(32'h0, 32'h0, "loop_run");

    // load_start and start together from HALT: load wins.
    pulse(1'b1, 1'b1);
    check_eq("both_state_load", state_dbg, 1);
    check_eq("both_busy", busy, 1);
    check_eq("both_loaded_clr", loaded, 0);
    check_eq("both_cpu_reset", cpu_reset, 1);
    load_buf[0] = I_ADDI1; load_buf[1] = I_SW; load_buf[2] = I_ECALL;
    stream_words(3, 1'b1, "store_prog");
    run_and_check(TOHOST, 32'd1, "tohost_pass");
    run_and_check(TOHOST, 32'd2, "tohost_fail");
    run_and_check(32'h0000_2000, 32'd1, "other_store");

    // Image longer than imem with no last marker.
    for (int i = 0; i < 6; i++) load_buf[i] = (i == 5) ? I_ECALL : I_ADDI1;
    load_image(6, 1'b0, "ovf_prog");
    run_and_check(32'h0, 32'h0, "ovf_run");

    // Exactly DEPTH words with last on the final one: no overflow.
    for (int i = 0; i < DEPTH; i++) load_buf[i] = (i == DEPTH - 1) ? I_EBREAK : I_NOP;
    load_image(DEPTH, 1'b1, "full_prog");
    run_and_check(32'h0, 32'h0, "full_run");

    // Reset in the fifth RUN cycle aborts the run.
    load_buf[0] = I_JAL0;
    load_image(1, 1'b1, "abort_prog");
    pulse(1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      drive_cpu(32'h0, 32'h0, 32'h0);
      @(posedge clk); #1;
    end
    drive_cpu(32'h0, 32'h0, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("abort_state", state_dbg, 0);
    check_eq("abort_cpu_reset", cpu_reset, 1);
    check_eq("abort_loaded", loaded, 0);
    check_eq("abort_count", cycle_count, 0);
    check_eq("abort_done", done, 0);
    img_loaded = 1'b0;
    pulse(1'b0, 1'b1);
    check_eq("abort_start_ignored", state_dbg, 0);
    check_eq("abort_start_cpu_reset", cpu_reset, 1);

    // Random images, store traffic and reruns.
    for (int t = 0; t < 30; t++) begin
      if (!img_loaded || $urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 4) == 0) begin
          n = $urandom_range(DEPTH, DEPTH + 2);
          for (int i = 0; i < n; i++) load_buf[i] = rand_instr();
          load_image(n, 1'b0, "rnd_ovf_load");
        end else begin
          n = $urandom_range(1, DEPTH);
          for (int i = 0; i < n; i++) load_buf[i] = rand_instr();
          load_image(n, 1'b1, "rnd_load");
        end
      end
      sa = ($urandom_range(0, 2) != 0) ? TOHOST : 32'h0000_1004;
      sv = 32'($urandom_range(0, 2));
      run_and_check(sa, sv, "rnd_run");
    end

    check_eq("stray_imem_writes", obs_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
